uart_rx: RTL and testbench
==========================

# uart_rx

UART receiver for the 8-bit CPU's serial port: it recovers 8N1 frames from the `rx` pin and holds each received byte in a one-entry receive register until the CPU bus reads it. It is the receive counterpart to the UART transmitter. It uses the same bit period, 104 `clk` cycles per bit, so a looped-back `tx` line decodes cleanly. Framing and overrun errors are reported as sticky flags.

## Interface
- `CLKS_PER_BIT`, default 104: `clk` cycles per bit. Legal range is 8 or more, and the value must be even.
- `DATA_BITS`, default 8: data bits per frame, sent LSB first.
- `clk`  input  1  system clock; all logic runs on its rising edge.
- `reset`  input  1  asynchronous, active-high.
- `rx`  input  1  serial line. It is asynchronous to `clk` and idles high.
- `rd_en`  input  1  single-cycle read strobe from the bus; it pops the receive register.
- `clr_err`  input  1  single-cycle strobe; it clears `framing_err` and `overrun`.
- `data_out`  output  DATA_BITS  last committed byte.
- `data_valid`  output  1  the receive register holds an unread byte.
- `framing_err`  output  1  sticky; set when a stop bit is sampled low.
- `overrun`  output  1  sticky; set when a byte arrives while `data_valid`=1.
- `busy`  output  1  high while the FSM is not in IDLE.

## Operation
**Input synchronizer**
- `rx` passes through a 2-flop synchronizer; both flops reset to 1.
- A third flop `rx_prev` holds the previous synchronized value for edge detection.

**Counters**
- `bit_cnt` is $clog2(CLKS_PER_BIT) bits wide. It is cleared on every state entry and on every bit sample.
- `bit_idx` is $clog2(DATA_BITS) bits wide.

**FSM states**
- IDLE
  - On synced `rx`=0 with `rx_prev`=1 (falling edge): clear `bit_cnt`, go to START.
  - A line held low with no falling edge never starts a frame.
- START
  - When `bit_cnt` = CLKS_PER_BIT/2-1, sample the line (mid start bit).
  - Sample 0: go to DATA with `bit_idx`=0.
  - Sample 1: treat as a glitch and return to IDLE, with no flags changed.
- DATA
  - When `bit_cnt` = CLKS_PER_BIT-1, sample the line into shift register bit `bit_idx`.
  - After bit DATA_BITS-1 go to STOP; otherwise increment `bit_idx`.
- STOP
  - When `bit_cnt` = CLKS_PER_BIT-1, sample the line and return to IDLE.
  - Sample 1 commits the byte.
  - Sample 0 sets `framing_err` and discards the byte; `data_out` and `data_valid` are unchanged.

**Commit and read rules**
- Commit with `data_valid`=0: load `data_out` and set `data_valid`.
- Commit with `data_valid`=1 and `rd_en`=0: set `overrun`. The new byte is discarded and the held byte is kept.
- Commit and `rd_en` in the same cycle: load the new byte, keep `data_valid`=1, leave `overrun` unchanged.
- `rd_en` with no commit: clear `data_valid`. `data_out` keeps its last value.
- `rd_en` while `data_valid`=0: no effect.

**Error flag rules**
- `clr_err` and an error event in the same cycle: the flag ends up set.
- `framing_err` and `overrun` stay set until `clr_err` or `reset`.

## Timing
**Reset**
- `data_out`=0, `data_valid`=0, `framing_err`=0, `overrun`=0, `busy`=0.
- FSM in IDLE, synchronizer flops at 1.
- Reset applied mid-frame abandons the frame immediately.
- After reset the line must show a fresh falling edge before a frame is detected.

**Sample points** (D is the cycle the falling edge is detected, at least 2 cycles after the pin edge)
- Start bit sampled at D+CLKS_PER_BIT/2.
- Data bit i sampled at D+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
- Stop bit sampled at D+CLKS_PER_BIT/2+(DATA_BITS+1)·CLKS_PER_BIT, which is D+988 at the defaults.

**Output timing**
- `data_valid`, `framing_err` and `overrun` update on the clock edge after the stop sample (D+989 at the defaults).
- `busy` rises at D+1 and falls on the same edge as the stop-sample flag update.

**Frame spacing and tolerance**
- The FSM is back in IDLE half a bit before the end of the stop bit, so back-to-back frames with zero idle time are received.
- Tolerates up to ±4% baud mismatch.

## Test plan
1. Reset, then a frame 0x48 ('H') at 104 clk/bit: `data_valid` rises at D+989 with `data_out`=0x48. After `rd_en`, `data_valid`=0 and `data_out` stays 0x48.
2. A 40-cycle low glitch on an idle line: `busy` pulses, FSM returns to IDLE, no `data_valid`, no flags.
3. Frame 0xA5 with stop bit driven 0: `framing_err`=1, `data_valid` stays 0. After `clr_err`, `framing_err`=0.
4. Back-to-back 0x00 then 0xFF with no read between: `data_out`=0x00, `overrun`=1. Then `rd_en` gives `data_valid`=0.
5. `rd_en` pulsed exactly on the second byte's commit cycle of 0x11, 0x22: `data_out`=0x22, `data_valid`=1, `overrun`=0.
6. `reset` asserted after data bit 3 of a frame, then a full 0x5A frame: all outputs 0 during reset, then 0x5A is received correctly and no flags are set.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-entry receive register and sticky framing/overrun flags.
// Samples mid-bit relative to the synchronized falling edge of the start bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               state_r, state_nxt;
  logic [CW-1:0]        cnt_r, cnt_nxt;
  logic [IW-1:0]        idx_r, idx_nxt;
  logic [DATA_BITS-1:0] shift_r, shift_nxt;
  logic                 rx_meta_r, rx_sync_r, rx_prev_r;
  logic                 commit_s, ferr_s, ovr_s;

  // Two-flop synchronizer plus previous-value flop for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= {IW{1'b0}};
      shift_r <= {DATA_BITS{1'b0}};
      busy    <= 1'b0;
    end else begin
      state_r <= state_nxt;
      cnt_r   <= cnt_nxt;
      idx_r   <= idx_nxt;
      shift_r <= shift_nxt;
      busy    <= (state_nxt != S_IDLE);
    end
  end

  // Next-state logic; a counter match is a sample point and restarts the count.
  always_comb begin
    state_nxt = state_r;
    cnt_nxt   = cnt_r + CW'(1);
    idx_nxt   = idx_r;
    shift_nxt = shift_r;
    commit_s  = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        cnt_nxt = {CW{1'b0}};
        if (!rx_sync_r && rx_prev_r) begin
          state_nxt = S_START;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (cnt_r == HALF_M1) begin
          cnt_nxt = {CW{1'b0}};
          if (rx_sync_r) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            idx_nxt   = {IW{1'b0}};
          end
        end else begin
          state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt           = {CW{1'b0}};
          shift_nxt[idx_r]  = rx_sync_r;
          if (idx_r == LAST_IDX) begin
            state_nxt = S_STOP;
          end else begin
            idx_nxt = idx_r + IW'(1);
          end
        end else begin
          state_nxt = S_DATA;
        end
      end
      S_STOP: begin
        if (cnt_r == FULL_M1) begin
          cnt_nxt   = {CW{1'b0}};
          state_nxt = S_IDLE;
          if (rx_sync_r) begin
            commit_s = 1'b1;
          end else begin
            ferr_s = 1'b1;
          end
        end else begin
          state_nxt = S_STOP;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  assign ovr_s = commit_s && data_valid && !rd_en;

  // Receive register: a read in the commit cycle makes room for the new byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out   <= {DATA_BITS{1'b0}};
      data_valid <= 1'b0;
    end else if (commit_s) begin
      if (!data_valid || rd_en) begin
        data_out   <= shift_r;
        data_valid <= 1'b1;
      end else begin
        data_valid <= data_valid;
      end
    end else if (rd_en) begin
      data_valid <= 1'b0;
    end else begin
      data_valid <= data_valid;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (ferr_s) begin
        framing_err <= 1'b1;
      end else if (clr_err) begin
        framing_err <= 1'b0;
      end else begin
        framing_err <= framing_err;
      end
      if (ovr_s) begin
        overrun <= 1'b1;
      end else if (clr_err) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames scored against a frame-level model
// of the receive register and error flags.
module tb_uart_rx;

  localparam int CPB = 104;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, framing_err, overrun, busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_data;
  logic       m_valid, m_fe, m_ov;

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .data_out(data_out), .data_valid(data_valid), .framing_err(framing_err),
    .overrun(overrun), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".data"},  {24'd0, data_out}, {24'd0, m_data});
    chk({tag, ".valid"}, {31'd0, data_valid}, {31'd0, m_valid});
    chk({tag, ".fe"},    {31'd0, framing_err}, {31'd0, m_fe});
    chk({tag, ".ov"},    {31'd0, overrun}, {31'd0, m_ov});
  endtask

  // Frame-level reference: outcome of one complete frame, given strobes in its commit cycle.
  task automatic model_frame(input logic [7:0] d, input logic stop, input bit rd, input bit clr);
    logic ov_ev;
    ov_ev = 1'b0;
    if (stop) begin
      if (!m_valid || rd) begin
        m_data  = d;
        m_valid = 1'b1;
      end else begin
        ov_ev = 1'b1;
      end
    end else if (rd) begin
      m_valid = 1'b0;
    end
    m_fe = !stop ? 1'b1 : (clr ? 1'b0 : m_fe);
    m_ov = ov_ev ? 1'b1 : (clr ? 1'b0 : m_ov);
  endtask

  task automatic model_strobe(input bit rd, input bit clr);
    if (rd) m_valid = 1'b0;
    if (clr) begin
      m_fe = 1'b0;
      m_ov = 1'b0;
    end
  endtask

  // Drives one frame; k counts rising edges since the start-bit drive. Commit cycle is k=990.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int rd_at,
                            input int clr_at, input bit chk_t);
    for (int k = 0; k < 10 * CPB; k++) begin
      int b;
      @(negedge clk);
      b = k / CPB;
      if (chk_t) begin
        if (k == 2)   chk("busy_before_edge", {31'd0, busy}, 32'd0);
        if (k == 3)   chk("busy_rise", {31'd0, busy}, 32'd1);
        if (k == 990) chk("valid_before_commit", {31'd0, data_valid}, 32'd0);
        if (k == 990) chk("busy_before_stop", {31'd0, busy}, 32'd1);
        if (k == 991) chk("valid_at_commit", {31'd0, data_valid}, 32'd1);
        if (k == 991) chk("busy_fall", {31'd0, busy}, 32'd0);
      end
      rx      = (b == 0) ? 1'b0 : ((b <= 8) ? d[b-1] : stop_bit);
      rd_en   = (k == rd_at);
      clr_err = (k == clr_at);
    end
  endtask

  task automatic pulse(input bit rd, input bit clr);
    @(negedge clk);
    rd_en   = rd;
    clr_err = clr;
    @(negedge clk);
    rd_en   = 1'b0;
    clr_err = 1'b0;
    model_strobe(rd, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx = 1'b1;
    end
  endtask

  initial begin
    #6_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_errors++;
    $fatal(1, "Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
  end

  initial begin
    logic [7:0] d;
    logic       stop, prev_stop;
    int         gap;
    bit         rd_c, clr_c, rd_g, clr_g;

    m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_model("reset");
    chk("reset.busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    idle(5);

    // 1: 'H' with exact edge timing, then read
    send_frame(8'h48, 1'b1, -1, -1, 1'b1);
    model_frame(8'h48, 1'b1, 1'b0, 1'b0);
    chk("t1.data", {24'd0, data_out}, 32'h48);
    pulse(1'b1, 1'b0);
    chk("t1.rd_valid", {31'd0, data_valid}, 32'd0);
    chk("t1.rd_data", {24'd0, data_out}, 32'h48);

    // 2: 40-cycle glitch
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (k == 20) chk("t2.busy_pulse", {31'd0, busy}, 32'd1);
      rx = (k < 40) ? 1'b0 : 1'b1;
    end
    chk("t2.busy_idle", {31'd0, busy}, 32'd0);
    chk_model("t2");

    // 3: framing error, clear asserted in the error cycle loses, later clear wins
    send_frame(8'hA5, 1'b0, -1, 990, 1'b0);
    model_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    chk("t3.fe", {31'd0, framing_err}, 32'd1);
    chk("t3.valid", {31'd0, data_valid}, 32'd0);
    idle(3);
    pulse(1'b0, 1'b1);
    chk("t3.fe_clr", {31'd0, framing_err}, 32'd0);

    // 4: back-to-back 0x00, 0xFF without a read
    send_frame(8'h00, 1'b1, -1, -1, 1'b0);
    model_frame(8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1, -1, -1, 1'b0);
    model_frame(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("t4.data", {24'd0, data_out}, 32'h00);
    chk("t4.ov", {31'd0, overrun}, 32'd1);
    pulse(1'b1, 1'b0);
    chk("t4.rd_valid", {31'd0, data_valid}, 32'd0);
    pulse(1'b0, 1'b1);
    chk_model("t4");

    // 5: read exactly on the second commit
    send_frame(8'h11, 1'b1, -1, -1, 1'b0);
    model_frame(8'h11, 1'b1, 1'b0, 1'b0);
    send_frame(8'h22, 1'b1, 990, -1, 1'b0);
    model_frame(8'h22, 1'b1, 1'b1, 1'b0);
    chk("t5.data", {24'd0, data_out}, 32'h22);
    chk("t5.valid", {31'd0, data_valid}, 32'd1);
    chk("t5.ov", {31'd0, overrun}, 32'd0);

    // 6: reset after data bit 3, with a byte held
    d = 8'hC3;
    for (int k = 0; k < 5 * CPB; k++) begin
      @(negedge clk);
      rx = (k < CPB) ? 1'b0 : d[k / CPB - 1];
    end
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    m_data = 8'h00; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    chk_model("t6.reset");
    chk("t6.reset_busy", {31'd0, busy}, 32'd0);
    idle(2);
    reset = 1'b0;
    idle(5);
    chk("t6.idle_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1, -1, -1, 1'b1);
    model_frame(8'h5A, 1'b1, 1'b0, 1'b0);
    chk_model("t6");

    // Random frames against the model
    prev_stop = 1'b1;
    for (int n = 0; n < 30; n++) begin
      d     = 8'($urandom);
      stop  = ($urandom_range(0, 4) != 0);
      rd_c  = ($urandom_range(0, 4) == 0);
      clr_c = ($urandom_range(0, 5) == 0);
      gap   = $urandom_range(0, 4);
      if (!prev_stop && gap == 0) gap = 1;
      rd_g  = ($urandom_range(0, 2) == 0);
      clr_g = ($urandom_range(0, 3) == 0);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        rx      = 1'b1;
        rd_en   = (g == 0) && rd_g;
        clr_err = (g == 0) && clr_g;
      end
      if (gap > 0) model_strobe(rd_g, clr_g);
      send_frame(d, stop, rd_c ? 990 : -1, clr_c ? 990 : -1, 1'b0);
      model_frame(d, stop, rd_c, clr_c);
      chk_model($sformatf("rand%0d", n));
      prev_stop = stop;
    end
    idle(4);
    chk("final.busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
